// File: rtl/cu_pkg.sv
// -----------------------------------------------------------------------------
// cu_pkg
// Shared definitions for the accumulator-machine control unit.
//   - Instruction opcodes (IR[15:12]) OP_NOP .. OP_HALT
//   - ALU opcode encodings driven on ALU.opcode
//   - Control FSM state type cu_state_t
// Configuration macro: CU_INDIRECT_EN adds the IND/IWAIT states used by LOADX.
// -----------------------------------------------------------------------------
package cu_pkg;

   // Instruction opcodes
   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_LOAD  = 4'h1;
   localparam logic [3:0] OP_STORE = 4'h2;
   localparam logic [3:0] OP_ADD   = 4'h3;
   localparam logic [3:0] OP_SUB   = 4'h4;
   localparam logic [3:0] OP_AND   = 4'h5;
   localparam logic [3:0] OP_OR    = 4'h6;
   localparam logic [3:0] OP_XOR   = 4'h7;
   localparam logic [3:0] OP_SHL   = 4'h8;
   localparam logic [3:0] OP_SHR   = 4'h9;
   localparam logic [3:0] OP_JUMP  = 4'hA;
   localparam logic [3:0] OP_SKIPZ = 4'hB;
   localparam logic [3:0] OP_JUMPZ = 4'hC;
   localparam logic [3:0] OP_LOADI = 4'hD;
   localparam logic [3:0] OP_LOADX = 4'hE;
   localparam logic [3:0] OP_HALT  = 4'hF;

   // ALU opcode encodings
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b1000;
   localparam logic [3:0] ALU_OR  = 4'b1001;
   localparam logic [3:0] ALU_XOR = 4'b1010;
   localparam logic [3:0] ALU_SHL = 4'b0100;
   localparam logic [3:0] ALU_SHR = 4'b0101;

   // Control FSM states; the indirect pair only exists when LOADX is built
   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_FWAIT,
      S_DECODE,
      S_OPER,
      S_OWAIT,
`ifdef CU_INDIRECT_EN
      S_IND,
      S_IWAIT,
`endif
      S_EXEC,
      S_STORE
   } cu_state_t;

endpackage

// File: rtl/cu_decoder.sv
// -----------------------------------------------------------------------------
// cu_decoder
// Purely combinational instruction decoder: IR[15:12] -> control attributes.
// Ports:
//   i_opcode        [3:0]  instruction opcode field
//   o_alu_op        [3:0]  ALU opcode for ALU-type instructions, else 0000
//   o_needs_operand        instruction reads M[X] before EXEC
//   o_is_store             STORE instruction
//   o_is_halt              HALT instruction
//   o_is_branch            JUMP / SKIPZ / JUMPZ
//   o_writes_acc           EXEC writes AC
// Configuration macro: CU_INDIRECT_EN makes opcode E (LOADX) a memory-operand
// instruction; otherwise opcode E decodes as NOP.
// -----------------------------------------------------------------------------
module cu_decoder
   import cu_pkg::*;
(
   input  logic [3:0] i_opcode,
   output logic [3:0] o_alu_op,
   output logic       o_needs_operand,
   output logic       o_is_store,
   output logic       o_is_halt,
   output logic       o_is_branch,
   output logic       o_writes_acc
);

   always_comb begin
      o_alu_op        = ALU_ADD;
      o_needs_operand = 1'b0;
      o_is_store      = 1'b0;
      o_is_halt       = 1'b0;
      o_is_branch     = 1'b0;
      o_writes_acc    = 1'b0;
      case (i_opcode)
         OP_LOAD: begin
            o_needs_operand = 1'b1;
            o_writes_acc    = 1'b1;
         end
         OP_STORE: o_is_store = 1'b1;
         OP_ADD: begin
            o_alu_op        = ALU_ADD;
            o_needs_operand = 1'b1;
            o_writes_acc    = 1'b1;
         end
         OP_SUB: begin
            o_alu_op        = ALU_SUB;
            o_needs_operand = 1'b1;
            o_writes_acc    = 1'b1;
         end
         OP_AND: begin
            o_alu_op        = ALU_AND;
            o_needs_operand = 1'b1;
            o_writes_acc    = 1'b1;
         end
         OP_OR: begin
            o_alu_op        = ALU_OR;
            o_needs_operand = 1'b1;
            o_writes_acc    = 1'b1;
         end
         OP_XOR: begin
            o_alu_op        = ALU_XOR;
            o_needs_operand = 1'b1;
            o_writes_acc    = 1'b1;
         end
         OP_SHL: begin
            o_alu_op     = ALU_SHL;
            o_writes_acc = 1'b1;
         end
         OP_SHR: begin
            o_alu_op     = ALU_SHR;
            o_writes_acc = 1'b1;
         end
         OP_JUMP, OP_SKIPZ, OP_JUMPZ: o_is_branch = 1'b1;
         OP_LOADI: o_writes_acc = 1'b1;
`ifdef CU_INDIRECT_EN
         OP_LOADX: begin
            o_needs_operand = 1'b1;
            o_writes_acc    = 1'b1;
         end
`endif
         OP_HALT: o_is_halt = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/cpu_control_unit.sv
// -----------------------------------------------------------------------------
// cpu_control_unit
// Fetch/decode/execute sequencer for the 16-bit accumulator datapath. Owns PC,
// IR, MBR and AC; drives MainMemory (registered reads, 1-cycle latency) and the
// ALU operand/opcode ports.
// Parameters:
//   PC_W      PC / operand-address width (addresses zero-extended to 16 bits)
//   RESET_PC  PC value loaded on reset
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             level, sampled only in IDLE
//   mem_rdata  [15:0] MainMemory.data_out
//   alu_result [15:0] ALU.result
//   mem_addr   [15:0] MainMemory.addr
//   mem_wdata  [15:0] MainMemory.data_in (= AC)
//   mem_we            MainMemory.write_enable (STORE state, gated by reset)
//   alu_op     [3:0]  ALU.opcode (decoded op in EXEC, else 0000)
//   alu_a/alu_b[15:0] ALU operands (= AC / MBR)
//   acc        [15:0] AC contents
//   pc         [PC_W-1:0] PC contents
//   busy              high in every state except IDLE
//   halted            set by HALT, cleared by start or reset
// Configuration macro: CU_INDIRECT_EN builds LOADX (AC <= M[M[X]]) with the
// IND/IWAIT states; without it opcode E behaves as NOP.
// -----------------------------------------------------------------------------
module cpu_control_unit
   import cu_pkg::*;
#(
   parameter int unsigned     PC_W     = 12,
   parameter logic [PC_W-1:0] RESET_PC = '0
)
(
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [15:0]     mem_rdata,
   input  logic [15:0]     alu_result,
   output logic [15:0]     mem_addr,
   output logic [15:0]     mem_wdata,
   output logic            mem_we,
   output logic [3:0]      alu_op,
   output logic [15:0]     alu_a,
   output logic [15:0]     alu_b,
   output logic [15:0]     acc,
   output logic [PC_W-1:0] pc,
   output logic            busy,
   output logic            halted
);

   cu_state_t       r_state;
   cu_state_t       w_next_state;
   logic [PC_W-1:0] r_pc;
   logic [15:0]     r_ir;
   logic [15:0]     r_mbr;
   logic [15:0]     r_ac;
   logic            r_halted;

   logic [3:0]      w_opcode;
   logic [11:0]     w_x;
   logic [PC_W-1:0] w_x_pc;
   logic [PC_W-1:0] w_pc_inc;
   logic            w_ac_zero;
   logic [15:0]     w_ac_next;

   logic [3:0]      w_alu_op;
   logic            w_needs_operand;
   logic            w_is_store;
   logic            w_is_halt;
   logic            w_is_branch;
   logic            w_writes_acc;

   assign w_opcode  = r_ir[15:12];
   assign w_x       = r_ir[11:0];
   assign w_x_pc    = PC_W'(w_x);
   assign w_pc_inc  = r_pc + PC_W'(1);   // natural wrap at 2^PC_W
   assign w_ac_zero = (r_ac == '0);

   cu_decoder u_decoder (
      .i_opcode        (w_opcode),
      .o_alu_op        (w_alu_op),
      .o_needs_operand (w_needs_operand),
      .o_is_store      (w_is_store),
      .o_is_halt       (w_is_halt),
      .o_is_branch     (w_is_branch),
      .o_writes_acc    (w_writes_acc)
   );

   // ---------------------------------------------------------------- FSM state
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // ------------------------------------------------------------ FSM next state
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next_state = S_FETCH;
         S_FETCH:  w_next_state = S_FWAIT;
         S_FWAIT:  w_next_state = S_DECODE;
         S_DECODE: begin
            if (w_is_halt)            w_next_state = S_IDLE;
            else if (w_is_store)      w_next_state = S_STORE;
            else if (w_needs_operand) w_next_state = S_OPER;
            else                      w_next_state = S_EXEC;
         end
         S_OPER:   w_next_state = S_OWAIT;
`ifdef CU_INDIRECT_EN
         S_OWAIT:  w_next_state = (w_opcode == OP_LOADX) ? S_IND : S_EXEC;
         S_IND:    w_next_state = S_IWAIT;
         S_IWAIT:  w_next_state = S_EXEC;
`else
         S_OWAIT:  w_next_state = S_EXEC;
`endif
         S_EXEC:   w_next_state = S_FETCH;
         S_STORE:  w_next_state = S_FETCH;
         default:  w_next_state = S_IDLE;
      endcase
   end

   // --------------------------------------------------------------- FSM outputs
   // mem_addr defaults to PC so IDLE/FETCH present the next instruction address.
   always_comb begin
      mem_addr = 16'(r_pc);
      mem_we   = 1'b0;
      alu_op   = ALU_ADD;
      busy     = (r_state != S_IDLE);
      case (r_state)
         S_OPER:  mem_addr = {4'b0, w_x};
         S_STORE: begin
            mem_addr = {4'b0, w_x};
            mem_we   = ~reset;   // a reset in the STORE cycle must not write
         end
`ifdef CU_INDIRECT_EN
         S_IND:   mem_addr = r_mbr;
`endif
         S_EXEC:  alu_op = w_alu_op;
         default: ;
      endcase
   end

   // AC source selection for instructions that write the accumulator
   always_comb begin
      w_ac_next = alu_result;
      case (w_opcode)
         OP_LOADI:          w_ac_next = {4'b0, w_x};
         OP_LOAD, OP_LOADX: w_ac_next = r_mbr;
         default: ;
      endcase
   end

   // ------------------------------------------------------------- datapath regs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc     <= RESET_PC;
         r_ir     <= '0;
         r_mbr    <= '0;
         r_ac     <= '0;
         r_halted <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE:   if (start) r_halted <= 1'b0;
            S_FWAIT: begin
               r_ir <= mem_rdata;
               r_pc <= w_pc_inc;
            end
            S_DECODE: if (w_is_halt) r_halted <= 1'b1;
            S_OWAIT:  r_mbr <= mem_rdata;
`ifdef CU_INDIRECT_EN
            S_IWAIT:  r_mbr <= mem_rdata;
`endif
            S_EXEC: begin
               if (w_writes_acc) r_ac <= w_ac_next;
               if (w_is_branch) begin
                  case (w_opcode)
                     OP_JUMP:  r_pc <= w_x_pc;
                     OP_SKIPZ: if (w_ac_zero) r_pc <= w_pc_inc;
                     OP_JUMPZ: if (w_ac_zero) r_pc <= w_x_pc;
                     default: ;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_wdata = r_ac;
   assign alu_a     = r_ac;
   assign alu_b     = r_mbr;
   assign acc       = r_ac;
   assign pc        = r_pc;
   assign halted    = r_halted;

endmodule

// File: doc/cpu_control_unit.md
# cpu_control_unit

Fetch/decode/execute sequencer for the 16-bit accumulator datapath. It owns PC, IR, MBR and AC, drives the `ALU` operand and opcode ports, and drives the `MainMemory` address, data and write-enable ports. Memory reads are registered, with 1-cycle latency. It sits between `MainMemory` and `ALU` as the core's only controller. Instruction word format: [15:12] opcode, [11:0] operand address or immediate.

## Interface
- `PC_W`, default 12: PC and operand-address width. Memory addresses are zero-extended to 16 bits.
- `RESET_PC`, default 0: PC value loaded on reset.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high; overrides all other inputs.
- `start` input 1: level; sampled only in IDLE.
- `mem_rdata` input 16: `MainMemory.data_out`.
- `alu_result` input 16: `ALU.result`.
- `mem_addr` output 16: to `MainMemory.addr`.
- `mem_wdata` output 16: to `MainMemory.data_in`; always equals AC.
- `mem_we` output 1: to `MainMemory.write_enable`.
- `alu_op` output 4: to `ALU.opcode`.
- `alu_a` output 16: to `ALU.operand1`; always equals AC.
- `alu_b` output 16: to `ALU.operand2`; always equals MBR.
- `acc` output 16: AC contents.
- `pc` output PC_W: PC contents.
- `busy` output 1: high in every state except IDLE.
- `halted` output 1: set by HALT, cleared by `start` or `reset`.

## Operation
- Reset values: state IDLE, `pc`=RESET_PC, AC=IR=MBR=0, `busy`=0, `halted`=0, `mem_we`=0, `alu_op`=0, `mem_addr`={0,RESET_PC}.
- States: IDLE, FETCH, FWAIT, DECODE, OPER, OWAIT, IND, IWAIT, EXEC, STORE.
- IDLE: `mem_addr`=PC. If `start`=1, go to FETCH and clear `halted`.
- FETCH: `mem_addr`=PC. Go to FWAIT.
- FWAIT: IR<=`mem_rdata`; PC<=PC+1, wrapping 2^PC_W−1 to 0. Go to DECODE.
- DECODE: dispatch on IR[15:12].
  - Memory-operand ops go to OPER.
  - STORE goes to STORE.
  - HALT sets `halted` and goes to IDLE.
  - All other opcodes go to EXEC.
- OPER: `mem_addr`={0,IR[11:0]}. Go to OWAIT.
- OWAIT: MBR<=`mem_rdata`. Go to EXEC.
- EXEC: perform the op, then go to FETCH.
- STORE: `mem_addr`={0,IR[11:0]}, `mem_we`=1. Go to FETCH.
- Opcodes:
  - 0 NOP: no effect.
  - 1 LOAD: AC<=MBR.
  - 2 STORE: M[X]<=AC.
  - 3 ADD: AC<=ALU op 0000.
  - 4 SUB: AC<=ALU op 0001.
  - 5 AND: AC<=ALU op 1000.
  - 6 OR: AC<=ALU op 1001.
  - 7 XOR: AC<=ALU op 1010.
  - 8 SHL: AC<=ALU op 0100.
  - 9 SHR: AC<=ALU op 0101.
  - A JUMP: PC<=X.
  - B SKIPZ: if AC==0, PC<=PC+1 (wraps).
  - C JUMPZ: if AC==0, PC<=X.
  - D LOADI: AC<={4'b0,X}.
  - E LOADX: see Configuration.
  - F HALT.
- Memory-operand opcodes: 1, 3–7, and E when enabled.
- `alu_op` carries the decoded op in EXEC and is 0000 in all other states.
- All arithmetic is 16-bit modulo. No flags are kept.
- `mem_we` equals (state==STORE) & ~`reset`. A `reset` asserted in a STORE cycle must produce no memory write.
- `start` outside IDLE is ignored.

## Timing
- Instruction cycles, counted from FETCH entry to the next FETCH entry:
  - NOP, SHL, SHR, JUMP, SKIPZ, JUMPZ, LOADI: 4.
  - STORE: 4.
  - LOAD and ALU-memory ops: 6.
  - LOADX: 8.
  - HALT: 3, from FETCH to IDLE.
- A memory read is issued in FETCH/OPER/IND. Data is consumed in the following FWAIT/OWAIT/IWAIT.
- AC, PC and `halted` update on the edge leaving EXEC/DECODE. New values are visible in the next cycle.
- Reset in any state: the next cycle is IDLE with all reset values. IR, MBR and AC contents are discarded.

## Configuration
- `CU_INDIRECT_EN` defined:
  - Opcode E LOADX: AC<=M[M[X]].
  - Path: OPER → OWAIT (MBR<=M[X]) → IND (`mem_addr`=MBR) → IWAIT (MBR<=`mem_rdata`) → EXEC (AC<=MBR).
  - The full 16-bit MBR is used as the address.
- `CU_INDIRECT_EN` undefined: opcode E decodes as NOP (4 cycles). IND and IWAIT are not built.

## Structure
- Package `cu_pkg` holds:
  - Opcode localparams OP_NOP…OP_HALT.
  - ALU opcode localparams ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR.
  - State enum `cu_state_t`.
- Sub-module `cu_decoder`, purely combinational: IR[15:12] → {alu_op, needs_operand, is_store, is_halt, is_branch, writes_acc}.
- The FSM, PC, IR, MBR and AC stay in `cpu_control_unit`.

## Test plan
- Program `M[0]=1010,M[1]=3011,M[2]=2012,M[3]=F000`, with `M[10]=0005`, `M[11]=0007`, start: → `M[12]`=000C; `halted`=1 after 19 cycles; `pc`=004.
- `M[0]=D000,M[1]=B000,M[2]=F000,M[3]=DFFF,M[4]=F000`: → SKIPZ skips `M[2]`; `acc`=0FFF; halts with `pc`=005.
- `PC_W`=12, RESET_PC=FFF, `M[FFF]=D123,M[000]=F000`: → PC wraps to 000; `acc`=0123; halts.
- Reset asserted during the STORE state of `2012`: → `M[12]` unchanged; IDLE next cycle; `pc`=RESET_PC; `acc`=0000.
- `M[0]=D8001`-style sequence: LOADI 800, SHL, SHL, … 4 times (`8800`×4 via opcode 8) → `acc`=8000, then 0000 on the 5th shift.
- With `CU_INDIRECT_EN`: `M[0]=E020,M[20]=0030,M[30]=BEEF` → `acc`=BEEF in 8 cycles. Without it: `acc`=0000 and `pc`=001 after 4 cycles.
